// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: start-up, load-use stall, jump flush, dmem freeze, halt drain.
// Optional performance counters are enabled with `define PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_halt,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_wr,
  input  logic       ex_mem_to_reg,
  input  logic       ex_jump_taken,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_reg_wr,
  input  logic       wb_reg_wr,
  input  logic       dmem_busy,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       pipe_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halted
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  localparam int unsigned DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

  if (DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_param_chk
    $error("pipe_hazard_ctrl: DRAIN_CYCLES and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e          state_q, state_d;
  logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
  logic            halted_q, halted_d;
  logic            load_use;
  logic [1:0]      fwd_a_raw, fwd_b_raw;

  // Forward select for one EX source: the youngest writer (MEM) wins over WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_wr,
                                         input logic [4:0] w_rd, input logic w_wr);
    if (m_wr && (m_rd != 5'd0) && (m_rd == rs))      return 2'd1;
    else if (w_wr && (w_rd != 5'd0) && (w_rd == rs)) return 2'd2;
    else                                             return 2'd0;
  endfunction

  assign fwd_a_raw = fwd_sel(id_rs1, mem_rd, mem_reg_wr, wb_rd, wb_reg_wr);
  assign fwd_b_raw = fwd_sel(id_rs2, mem_rd, mem_reg_wr, wb_rd, wb_reg_wr);

  assign load_use = ex_mem_to_reg && ex_reg_wr && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef PERF_CNT_EN
  logic             stall_inc, flush_inc, freeze_inc;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, freeze_cnt_d;
`endif

  // Next state and stage controls; enables respond to the current cycle's hazards.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    pipe_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
`ifdef PERF_CNT_EN
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    freeze_inc  = 1'b0;
`endif
    unique case (state_q)
      ST_START: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        fwd_a      = 2'd0;
        fwd_b      = 2'd0;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_busy) begin
`ifdef PERF_CNT_EN
          freeze_inc = 1'b1;
`endif
        end else if (ex_jump_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          pipe_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
`ifdef PERF_CNT_EN
          flush_inc  = 1'b1;
`endif
        end else if (load_use) begin
          pipe_en    = 1'b1;
          idex_flush = 1'b1;
`ifdef PERF_CNT_EN
          stall_inc  = 1'b1;
`endif
        end else if (id_halt) begin
          pipe_en     = 1'b1;
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          pipe_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        pipe_en    = !dmem_busy;
        ifid_flush = 1'b1;
        if (!dmem_busy) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + DC_W'(1);
          end
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign halted = halted_q;

`ifdef PERF_CNT_EN
  // Saturating event counters; they only move in RUN so they are frozen once halted.
  always_comb begin
    stall_cnt_d  = (stall_inc  && (stall_cnt_q  != '1)) ? stall_cnt_q  + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d  = (flush_inc  && (flush_cnt_q  != '1)) ? flush_cnt_q  + CNT_W'(1) : flush_cnt_q;
    freeze_cnt_d = (freeze_inc && (freeze_cnt_q != '1)) ? freeze_cnt_q + CNT_W'(1) : freeze_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, drain/reset sequences,
// and randomized traffic checked against a stage-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int P_START = 0, P_RUN = 1, P_DRAIN = 2, P_HALTED = 3;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  typedef struct packed {
    logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic halt;
    logic [4:0] ex_rd; logic ex_wr; logic ex_ld; logic jmp;
    logic [4:0] mem_rd; logic mem_wr; logic [4:0] wb_rd; logic wb_wr; logic busy;
  } vin_t;

  typedef struct packed {
    logic pc_en; logic ifid_en; logic pipe_en; logic ifid_flush; logic idex_flush;
    logic [1:0] fwd_a; logic [1:0] fwd_b; logic halted;
  } out_t;

  typedef struct packed { vin_t v; out_t e; } vec_t;

  logic       clk, rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, id_halt, ex_reg_wr, ex_mem_to_reg, ex_jump_taken;
  logic       mem_reg_wr, wb_reg_wr, dmem_busy;
  logic       pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, halted;
  logic [1:0] fwd_a, fwd_b;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model state: phase, non-busy drain cycles still owed, event totals
  int     m_phase, m_left, nx_phase, nx_left;
  longint m_stall, m_flush, m_freeze, nx_stall, nx_flush, nx_freeze;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_jump_taken(ex_jump_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .pipe_en(pipe_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input vin_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_halt = v.halt;
    ex_rd = v.ex_rd; ex_reg_wr = v.ex_wr; ex_mem_to_reg = v.ex_ld; ex_jump_taken = v.jmp;
    mem_rd = v.mem_rd; mem_reg_wr = v.mem_wr; wb_rd = v.wb_rd; wb_reg_wr = v.wb_wr;
    dmem_busy = v.busy;
  endtask

  function automatic out_t get_out();
    return '{pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, fwd_a, fwd_b, halted};
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input vin_t v);
    if (rs == 5'd0) return 2'd0;
    if (v.mem_wr && v.mem_rd == rs) return 2'd1;
    if (v.wb_wr && v.wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic longint sat_inc(input longint c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic model_reset();
    m_phase = P_START; m_left = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
  endtask

  // Expected outputs for this cycle and the model's state after the next edge.
  task automatic model_eval(input vin_t v, output out_t o);
    bit lu;
    lu = v.ex_ld && v.ex_wr && (v.ex_rd != 0) &&
         ((v.u1 && v.rs1 == v.ex_rd) || (v.u2 && v.rs2 == v.ex_rd));
    o = '0;
    o.fwd_a = fwd_ref(v.rs1, v);
    o.fwd_b = fwd_ref(v.rs2, v);
    nx_phase = m_phase; nx_left = m_left;
    nx_stall = m_stall; nx_flush = m_flush; nx_freeze = m_freeze;
    case (m_phase)
      P_START: begin
        o.fwd_a = 0; o.fwd_b = 0; o.ifid_flush = 1; o.idex_flush = 1;
        nx_phase = P_RUN;
      end
      P_RUN: begin
        if (v.busy) nx_freeze = sat_inc(m_freeze);
        else if (v.jmp) begin
          {o.pc_en, o.ifid_en, o.pipe_en, o.ifid_flush, o.idex_flush} = 5'b11111;
          nx_flush = sat_inc(m_flush);
        end else if (lu) begin
          o.pipe_en = 1; o.idex_flush = 1;
          nx_stall = sat_inc(m_stall);
        end else if (v.halt) begin
          o.pipe_en = 1;
          nx_phase = P_DRAIN; nx_left = DRAIN_CYCLES;
        end else {o.pc_en, o.ifid_en, o.pipe_en} = 3'b111;
      end
      P_DRAIN: begin
        o.pipe_en = !v.busy; o.ifid_flush = 1;
        if (!v.busy) begin
          nx_left = m_left - 1;
          if (nx_left == 0) nx_phase = P_HALTED;
        end
      end
      default: o.halted = 1;
    endcase
  endtask

  task automatic model_commit();
    m_phase = nx_phase; m_left = nx_left;
    m_stall = nx_stall; m_flush = nx_flush; m_freeze = nx_freeze;
  endtask

  task automatic check_out(input string nm, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b [pc,ifid,pipe,iff,idf,fa,fb,halted] t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_val(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_cnts(input string nm);
`ifdef PERF_CNT_EN
    check_val({nm, ".stall_cnt"},  longint'(stall_cnt),  m_stall);
    check_val({nm, ".flush_cnt"},  longint'(flush_cnt),  m_flush);
    check_val({nm, ".freeze_cnt"}, longint'(freeze_cnt), m_freeze);
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model at posedge.
  task automatic cyc(input vin_t v, input string nm, input bit use_tbl, input out_t texp);
    out_t mexp;
    model_eval(v, mexp);
    drive(v);
    @(negedge clk);
    check_out(nm, get_out(), use_tbl ? texp : mexp);
    check_cnts(nm);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle; START outputs must appear at once.
  task automatic mid_reset(input string nm);
    #2;
    rst_n = 1'b0;
    drive('0);
    model_reset();
    #1;
    check_out(nm, get_out(), out_t'(10'b00011_00_00_0));
    check_cnts(nm);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vin_t rand_vin();
    vin_t v;
    v.rs1 = 5'($urandom_range(0, 3));   v.rs2 = 5'($urandom_range(0, 3));
    v.u1 = 1'($urandom_range(0, 1));    v.u2 = 1'($urandom_range(0, 1));
    v.halt = ($urandom_range(0, 29) == 0);
    v.ex_rd = 5'($urandom_range(0, 3)); v.ex_wr = 1'($urandom_range(0, 1));
    v.ex_ld = ($urandom_range(0, 2) == 0);
    v.jmp = ($urandom_range(0, 7) == 0);
    v.mem_rd = 5'($urandom_range(0, 3)); v.mem_wr = 1'($urandom_range(0, 1));
    v.wb_rd = 5'($urandom_range(0, 3));  v.wb_wr = 1'($urandom_range(0, 1));
    v.busy = ($urandom_range(0, 5) == 0);
    return v;
  endfunction

  vec_t tbl[16];
  vin_t vz, vh;
  int   busy_pat[5] = '{0, 1, 1, 0, 0};

  initial begin
    // rs1 rs2 u1 u2 halt | ex_rd wr ld jmp | mem_rd wr wb_rd wr busy || pc ifid pipe iff idf fa fb halted
    tbl[0]  = '{'{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0}, '{1, 1, 1, 0, 0, 0, 0, 0}};
    tbl[1]  = '{'{5, 0, 1, 0, 0,  5, 1, 1, 0,  0, 0, 0, 0, 0}, '{0, 0, 1, 0, 1, 0, 0, 0}};
    tbl[2]  = '{'{0, 0, 1, 0, 0,  0, 1, 1, 0,  0, 0, 0, 0, 0}, '{1, 1, 1, 0, 0, 0, 0, 0}};
    tbl[3]  = '{'{3, 5, 1, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0, 0}, '{0, 0, 1, 0, 1, 0, 0, 0}};
    tbl[4]  = '{'{5, 0, 0, 0, 0,  5, 1, 1, 0,  0, 0, 0, 0, 0}, '{1, 1, 1, 0, 0, 0, 0, 0}};
    tbl[5]  = '{'{5, 0, 1, 0, 0,  5, 0, 1, 0,  0, 0, 0, 0, 0}, '{1, 1, 1, 0, 0, 0, 0, 0}};
    tbl[6]  = '{'{5, 0, 1, 0, 0,  5, 1, 0, 0,  0, 0, 0, 0, 0}, '{1, 1, 1, 0, 0, 0, 0, 0}};
    tbl[7]  = '{'{0, 0, 0, 0, 1,  0, 0, 0, 1,  0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 0, 0, 0}};
    tbl[8]  = '{'{5, 0, 1, 0, 0,  5, 1, 1, 1,  0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 0, 0, 0}};
    tbl[9]  = '{'{5, 0, 1, 0, 0,  5, 1, 1, 1,  0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[10] = '{'{7, 0, 0, 0, 0,  0, 0, 0, 0,  7, 1, 7, 1, 0}, '{1, 1, 1, 0, 0, 1, 0, 0}};
    tbl[11] = '{'{7, 0, 0, 0, 0,  0, 0, 0, 0,  7, 0, 7, 1, 0}, '{1, 1, 1, 0, 0, 2, 0, 0}};
    tbl[12] = '{'{0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 1, 0}, '{1, 1, 1, 0, 0, 0, 0, 0}};
    tbl[13] = '{'{9, 9, 0, 0, 0,  0, 0, 0, 0,  9, 0, 9, 1, 0}, '{1, 1, 1, 0, 0, 2, 2, 0}};
    tbl[14] = '{'{4, 6, 0, 0, 0,  0, 0, 0, 0,  6, 1, 4, 1, 1}, '{0, 0, 0, 0, 0, 2, 1, 0}};
    tbl[15] = '{'{0, 12, 0, 1, 0, 12, 1, 1, 0, 12, 1, 0, 0, 0}, '{0, 0, 1, 0, 1, 0, 1, 0}};

    vz = '0;
    rst_n = 1'b0;
    drive(vz);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", get_out(), out_t'(10'b00011_00_00_0));
    rst_n = 1'b1;

    // start-up: exactly one START cycle, then running
    cyc(vz, "start_cycle", 1'b1, out_t'(10'b00011_00_00_0));
    cyc(vz, "first_run",   1'b1, out_t'(10'b11100_00_00_0));

    for (int i = 0; i < 16; i++) cyc(tbl[i].v, $sformatf("tbl%0d", i), 1'b1, tbl[i].e);

`ifdef PERF_CNT_EN
    check_val("perf_stall_total",  longint'(stall_cnt),  3);
    check_val("perf_flush_total",  longint'(flush_cnt),  2);
    check_val("perf_freeze_total", longint'(freeze_cnt), 2);
`endif

    // halt with dmem busy for two of the drain cycles
    vh = '0;
    vh.halt = 1'b1;
    cyc(vh, "halt_issue", 1'b1, out_t'(10'b00100_00_00_0));
    for (int i = 0; i < 5; i++) begin
      vh = '0;
      vh.busy = 1'(busy_pat[i]);
      cyc(vh, $sformatf("drain%0d", i), 1'b0, '0);
    end
    @(negedge clk);
    check_val("halted_after_5_drain", longint'(halted), 1);
    @(posedge clk);
    #1;
    vh = '0; vh.halt = 1'b1; vh.jmp = 1'b1; vh.ex_ld = 1'b1;
    cyc(vh, "halted_sticky", 1'b1, out_t'(10'b00000_00_00_1));

    mid_reset("reset_from_halted");
    cyc(vz, "restart_cycle", 1'b0, '0);
    for (int i = 0; i < 6; i++) cyc(tbl[1].v, "loaduse_run", 1'b0, '0);
    mid_reset("reset_mid_run");

    // randomized traffic with occasional resets, mostly after halting
    for (int i = 0; i < 4000; i++) begin
      if ((m_phase == P_HALTED && $urandom_range(0, 3) == 0) || $urandom_range(0, 599) == 0)
        mid_reset("rand_reset");
      else
        cyc(rand_vin(), "rand", 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
